// File: rtl/hard_pkg.sv
// Shared defaults and loader state encoding for the
// hard-coefficient loader and its buffer.
package hard_pkg;

  localparam int NTAPS_DEF  = 64;
  localparam int NCOEFF_DEF = NTAPS_DEF + 1;
  localparam int WIDTH_DEF  = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_FULL,
    S_SHIFT_LO,
    S_SHIFT_HI
  } ld_state_t;

endpackage

// File: rtl/hard_coeff_buf.sv
// Coefficient buffer: one registered write port,
// one combinational read port, contents not reset.
module hard_coeff_buf #(
  parameter int DEPTH = 65,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Reads past the last entry return zero.
  assign rdata = (int'(raddr) < DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/hard_coeff_loader.sv
// Buffers NTAPS+1 host words, then streams them to the
// filter shift chain on a generated coefficient clock.
module hard_coeff_loader
  import hard_pkg::*;
#(
  parameter int NTAPS = NTAPS_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic                    commit,
  output logic signed [WIDTH-1:0] coeff_data,
  output logic                    coeff_clk,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int NCOEFF = NTAPS + 1;
  localparam int CW     = $clog2(NCOEFF + 1);

  localparam logic [CW-1:0] LAST  = CW'(NTAPS);
  localparam logic [CW-1:0] FULLC = CW'(NCOEFF);
  localparam logic [CW-1:0] ONE   = CW'(1);

  ld_state_t        state;
  logic [CW-1:0]    count;
  logic [CW-1:0]    k;
  logic [CW-1:0]    raddr;
  logic [WIDTH-1:0] rdata;
  logic             up;
  logic             accept;

  // up keeps wr_ready low until the first edge after reset.
  assign wr_ready = up &&
                    (state == S_IDLE || state == S_FILL);
  assign accept   = wr_valid && wr_ready;
  assign raddr    = (state == S_SHIFT_HI) ? k + ONE : '0;

  hard_coeff_buf #(
    .DEPTH (NCOEFF),
    .WIDTH (WIDTH),
    .AW    (CW)
  ) u_buf (
    .clk   (clk),
    .we    (accept),
    .waddr (count),
    .wdata (wr_data),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      count      <= '0;
      k          <= '0;
      coeff_clk  <= 1'b0;
      coeff_data <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      up         <= 1'b0;
    end else begin
      up   <= 1'b1;
      done <= 1'b0;
      unique case (state)
        S_IDLE, S_FILL: begin
          if (accept) begin
            count <= count + ONE;
            state <= (count == FULLC - ONE) ?
                     S_FULL : S_FILL;
          end
          // Commit is judged against the pre-write count.
          if (commit) begin
            err <= 1'b1;
          end else if (accept) begin
            err <= 1'b0;
          end
        end
        S_FULL: begin
          if (commit) begin
            state      <= S_SHIFT_LO;
            k          <= '0;
            busy       <= 1'b1;
            coeff_data <= rdata;
          end
        end
        S_SHIFT_LO: begin
          state     <= S_SHIFT_HI;
          coeff_clk <= 1'b1;
        end
        S_SHIFT_HI: begin
          coeff_clk <= 1'b0;
          if (k < LAST) begin
            k          <= k + ONE;
            coeff_data <= rdata;
            state      <= S_SHIFT_LO;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            count <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hard_coeff_loader.sv
// Directed bench for hard_coeff_loader with a streamed-word
// scoreboard and a shift-chain model of the filter.
module tb_hard_coeff_loader;
  import hard_pkg::*;

  localparam int NT = NTAPS_DEF;
  localparam int NC = NT + 1;
  localparam int W  = WIDTH_DEF;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic signed [W-1:0] wr_data = '0;
  logic                wr_valid = 1'b0;
  logic                commit = 1'b0;
  logic                wr_ready;
  logic signed [W-1:0] coeff_data;
  logic                coeff_clk;
  logic                busy;
  logic                done;
  logic                err;

  always #5 clk = ~clk;

  hard_coeff_loader #(.NTAPS(NT), .WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .commit     (commit),
    .coeff_data (coeff_data),
    .coeff_clk  (coeff_clk),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  int nchk = 0;
  int nerr = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mb[NC];
  logic [W-1:0] chain[NC];
  int           mcnt = 0;
  logic         merr = 1'b0;
  int           pulses = 0;
  int           busy_cnt = 0;
  logic         prev_clk = 1'b0;
  logic [W-1:0] prev_data = '0;

  task automatic chk(input string name,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // Monitor: pops expected words on each coeff_clk rise.
  always @(negedge clk) begin
    if (!reset) begin
      prev_clk  = 1'b0;
      prev_data = coeff_data;
    end else begin
      if (busy) busy_cnt++;
      if (coeff_clk && !prev_clk) begin
        pulses++;
        chk("setup_stable", coeff_data, prev_data);
        if (exp_q.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL unexpected_pulse: got %h expected none",
                   coeff_data);
        end else begin
          chk("stream_word", coeff_data, exp_q.pop_front());
        end
        for (int j = 0; j < NC - 1; j++) chain[j] = chain[j+1];
        chain[NC-1] = coeff_data;
      end
      prev_clk  = coeff_clk;
      prev_data = coeff_data;
    end
  end

  task automatic do_write(input logic [W-1:0] d,
                          input logic with_commit);
    chk("wr_ready", {31'b0, wr_ready}, (mcnt < NC) ? 1 : 0);
    wr_data  = d;
    wr_valid = 1'b1;
    commit   = with_commit;
    @(negedge clk);
    wr_valid = 1'b0;
    commit   = 1'b0;
    if (mcnt < NC) begin
      mb[mcnt] = d;
      mcnt++;
      merr = 1'b0;
    end
    if (with_commit) merr = 1'b1;
    chk("err_after_write", {31'b0, err}, {31'b0, merr});
  endtask

  task automatic do_commit();
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    if (mcnt == NC) begin
      for (int i = 0; i < NC; i++) exp_q.push_back(mb[i]);
    end else begin
      merr = 1'b1;
    end
    chk("err_after_commit", {31'b0, err}, {31'b0, merr});
  endtask

  task automatic run_stream(input bit recommit);
    int p0;
    int b0;
    int cyc;
    p0  = pulses;
    b0  = busy_cnt;
    cyc = 0;
    do_commit();
    chk("busy_rise", {31'b0, busy}, 1);
    chk("cclk_low_first", {31'b0, coeff_clk}, 0);
    while (!done && cyc < 300) begin
      if (recommit && cyc == 40) commit = 1'b1;
      @(negedge clk);
      commit = 1'b0;
      cyc++;
    end
    chk("done_latency", cyc, 2 * NC);
    chk("pulse_count", pulses - p0, NC);
    chk("busy_cycles", busy_cnt - b0, 2 * NC);
    chk("busy_low_at_done", {31'b0, busy}, 0);
    @(negedge clk);
    chk("done_one_cycle", {31'b0, done}, 0);
    chk("data_hold_idle", coeff_data, mb[NC-1]);
    chk("wr_ready_after", {31'b0, wr_ready}, 1);
    mcnt = 0;
  endtask

  initial begin
    int p0;
    int cyc;
    logic [W-1:0] e;

    repeat (2) @(negedge clk);
    chk("rst_cclk", {31'b0, coeff_clk}, 0);
    chk("rst_data", coeff_data, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_err", {31'b0, err}, 0);
    chk("rst_wr_ready", {31'b0, wr_ready}, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("wr_ready_post_reset", {31'b0, wr_ready}, 1);

    // Ramp 1..0x41, overflow attempt, recommit mid-stream.
    for (int i = 0; i < NC; i++) do_write(W'(i + 1), 1'b0);
    chk("wr_ready_full", {31'b0, wr_ready}, 0);
    wr_data  = 32'hDEAD_BEEF;
    wr_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("wr_ready_held_full", {31'b0, wr_ready}, 0);
    end
    wr_valid = 1'b0;
    run_stream(1'b1);
    for (int i = 0; i < NC; i++)
      chk($sformatf("ramp_slot%0d", i), chain[i], W'(i + 1));

    // Underrun commit, err clear, write+commit, filter set.
    for (int i = 0; i < 10; i++)
      do_write((i == 0) ? 32'h800 : 32'h0, 1'b0);
    p0 = pulses;
    do_commit();
    repeat (4) @(negedge clk);
    chk("no_pulse_on_underrun", pulses - p0, 0);
    chk("wr_ready_underrun", {31'b0, wr_ready}, 1);
    chk("err_sticky", {31'b0, err}, 1);
    do_write(32'h0, 1'b0);
    do_write(32'h0, 1'b1);
    for (int i = 12; i < NT; i++) do_write(32'h0, 1'b0);
    do_write(32'h0040_0000, 1'b0);
    run_stream(1'b0);
    for (int i = 0; i < NC; i++) begin
      e = (i == 0) ? 32'h800 : (i == NT) ? 32'h40_0000 : 32'h0;
      chk($sformatf("filter_slot%0d", i), chain[i], e);
    end

    // Negative words, reset at pulse 20.
    for (int i = 0; i < NC; i++)
      do_write(32'h8000_0000 + W'(i), 1'b0);
    p0  = pulses;
    cyc = 0;
    do_commit();
    while (pulses - p0 < 20 && cyc < 200) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("abort_point", pulses - p0, 20);
    chk("cclk_high_before_abort", {31'b0, coeff_clk}, 1);
    reset = 1'b0;
    #1;
    chk("abort_cclk", {31'b0, coeff_clk}, 0);
    chk("abort_data", coeff_data, 0);
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_wr_ready", {31'b0, wr_ready}, 0);
    exp_q.delete();
    mcnt = 0;
    merr = 1'b0;
    repeat (2) @(negedge clk);
    p0 = pulses;
    reset = 1'b1;
    @(negedge clk);
    chk("release_wr_ready", {31'b0, wr_ready}, 1);
    chk("release_err", {31'b0, err}, 0);
    chk("no_pulse_after_abort", pulses - p0, 0);
    for (int i = 0; i < NC; i++)
      do_write(32'hA5A5_0000 ^ W'(i * 3), 1'b0);
    run_stream(1'b0);
    for (int i = 0; i < NC; i++)
      chk($sformatf("reload_slot%0d", i), chain[i], mb[i]);

    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
